// File: rtl/neuraedge_pe_pkg.sv
// Shared types and helpers for the NeuraEdge SIMD processing element.
package neuraedge_pe_pkg;

    localparam int unsigned MAX_ACC_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } pe_state_e;

    // Largest positive value of a w-bit signed number, zero-extended to MAX_ACC_W.
    function automatic logic [MAX_ACC_W-1:0] sat_max(input int unsigned w);
        return (MAX_ACC_W'(1) << (w - 1)) - MAX_ACC_W'(1);
    endfunction

    // Most negative w-bit signed value; only the low w bits are meaningful.
    function automatic logic [MAX_ACC_W-1:0] sat_min(input int unsigned w);
        return MAX_ACC_W'(1) << (w - 1);
    endfunction

    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
        return lane * w;
    endfunction

endpackage

// File: rtl/neuraedge_mac_lane.sv
// One signed MAC lane: multiply, extend, saturating/wrapping add, accumulator and sticky overflow flag.
module neuraedge_mac_lane
    import neuraedge_pe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned ACCUM_WIDTH  = 32,
    parameter int unsigned SATURATE     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [DATA_WIDTH-1:0]   data,
    input  logic signed [WEIGHT_WIDTH-1:0] weight,
    input  logic                           en,
    input  logic                           load,
    input  logic                           acc,
    output logic signed [ACCUM_WIDTH-1:0]  accum,
    output logic                           sat_flag
);

    localparam int unsigned PROD_W = DATA_WIDTH + WEIGHT_WIDTH;
    localparam int unsigned SUM_W  = ACCUM_WIDTH + 1;
    localparam logic [ACCUM_WIDTH-1:0] ACC_MAX = ACCUM_WIDTH'(sat_max(ACCUM_WIDTH));
    localparam logic [ACCUM_WIDTH-1:0] ACC_MIN = ACCUM_WIDTH'(sat_min(ACCUM_WIDTH));

    logic signed [PROD_W-1:0]      product;
    logic signed [SUM_W-1:0]       prod_ext;
    logic signed [SUM_W-1:0]       sum;
    logic                          overflow;
    logic        [ACCUM_WIDTH-1:0] sum_next;

    assign product  = data * weight;
    assign prod_ext = SUM_W'(product);
    assign sum      = SUM_W'(accum) + prod_ext;
    assign overflow = sum[SUM_W-1] ^ sum[SUM_W-2];

    // Clamp toward the sign of the true (ACCUM_WIDTH+1)-bit sum.
    always_comb begin
        sum_next = sum[ACCUM_WIDTH-1:0];
        if (SATURATE != 0 && overflow) begin
            sum_next = sum[SUM_W-1] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            accum    <= '0;
            sat_flag <= 1'b0;
        end else if (en) begin
            if (load) begin
                accum    <= ACCUM_WIDTH'(product);
                sat_flag <= 1'b0;
            end else if (acc) begin
                accum <= sum_next;
                if (overflow) begin
                    sat_flag <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/neuraedge_pe_simd.sv
// Multi-lane systolic PE: broadcast activation, per-lane MAC, forwarding stage and valid/ready result drain.
module neuraedge_pe_simd
    import neuraedge_pe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned ACCUM_WIDTH  = 32,
    parameter int unsigned LANES        = 4,
    parameter int unsigned SATURATE     = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic [LANES*WEIGHT_WIDTH-1:0]   weight_in,
    input  logic                            data_valid,
    input  logic                            start,
    input  logic                            last,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic [LANES*WEIGHT_WIDTH-1:0]   weight_out,
    output logic                            data_valid_out,
    output logic                            start_out,
    output logic                            last_out,
    output logic [LANES*ACCUM_WIDTH-1:0]    accum_out,
    output logic                            accum_valid,
    input  logic                            accum_ready,
    output logic [LANES-1:0]                sat_flag,
    output logic                            overrun,
    output logic                            busy
);

    pe_state_e state_q, state_d;
    logic      load_c, acc_c, overrun_c;
    logic      start_beat;

    assign start_beat = data_valid && start;

    // Forwarding stage to the next PE; never stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out       <= '0;
            weight_out     <= '0;
            data_valid_out <= 1'b0;
            start_out      <= 1'b0;
            last_out       <= 1'b0;
        end else begin
            data_out       <= data_in;
            weight_out     <= weight_in;
            data_valid_out <= data_valid;
            start_out      <= start;
            last_out       <= last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            accum_valid <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_q     <= state_d;
            accum_valid <= (state_d == DRAIN);
            busy        <= (state_d != IDLE);
            overrun     <= overrun_c;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_c    = 1'b0;
        acc_c     = 1'b0;
        overrun_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_beat) begin
                    load_c  = 1'b1;
                    state_d = last ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                if (start_beat) begin
                    load_c  = 1'b1;
                    state_d = last ? DRAIN : ACCUM;
                end else if (data_valid) begin
                    acc_c = 1'b1;
                    if (last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Result is held until the collector takes it; a start in the
                // handshake cycle chains straight into the next tile.
                if (accum_ready) begin
                    if (start_beat) begin
                        load_c  = 1'b1;
                        state_d = last ? DRAIN : ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (start_beat) begin
                    overrun_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        neuraedge_mac_lane #(
            .DATA_WIDTH  (DATA_WIDTH),
            .WEIGHT_WIDTH(WEIGHT_WIDTH),
            .ACCUM_WIDTH (ACCUM_WIDTH),
            .SATURATE    (SATURATE)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .data    (data_in),
            .weight  (weight_in[lane_lsb(i, WEIGHT_WIDTH) +: WEIGHT_WIDTH]),
            .en      (data_valid),
            .load    (load_c),
            .acc     (acc_c),
            .accum   (accum_out[lane_lsb(i, ACCUM_WIDTH) +: ACCUM_WIDTH]),
            .sat_flag(sat_flag[i])
        );
    end

endmodule
